i2s_refill_ctrl: RTL and testbench
==================================

Name: i2s_refill_ctrl

Overview:
- Ping-pong refill controller for the transmitter sample RAM in front of the I2S codec.
- On enable, primes the whole RAM from a streaming source over a valid/ready handshake.
- Afterwards, refills the lower or upper half each time the codec reports that half consumed (evt_lsbf / evt_hsbf).
- Drives the RAM write port (data_in / wr_en / wr_addr of the transmitter top); flags refill underruns.

Parameters:
DATA_WIDTH, 16, sample word width
ADDR_WIDTH, 14, RAM address width; buffer depth = 2**ADDR_WIDTH, half = 2**(ADDR_WIDTH-1)

Ports:
wb_clk  input  1  system clock, all logic rising-edge
wb_rst  input  1  reset, asynchronous, active-low
ctrl_en  input  1  controller enable; level
clr_err  input  1  one-cycle pulse, clears underrun
evt_lsbf  input  1  one-cycle pulse: lower half consumed, free for refill
evt_hsbf  input  1  one-cycle pulse: upper half consumed, free for refill
src_dat  input  DATA_WIDTH  source sample
src_valid  input  1  source sample valid
src_ready  output  1  controller accepts sample
mem_dat  output  DATA_WIDTH  RAM write data
mem_wr_en  output  1  RAM write strobe
mem_wr_addr  output  ADDR_WIDTH  RAM write address
primed  output  1  whole buffer loaded since enable; codec may be enabled
busy  output  1  state is not IDLE or WAIT
underrun  output  1  sticky: a half was consumed again before its refill completed

Behaviour:
- Reset (wb_rst=0) sets all outputs to 0, state to IDLE, and clears pend_lo, pend_hi and the address counter.
- States:
  - IDLE: src_ready=0. ctrl_en=1 -> PRIME; addr=0; underrun and primed cleared.
  - PRIME: src_ready=1. Each handshake (src_valid&src_ready) writes to addr, then addr+1. The handshake at addr=2**ADDR_WIDTH-1 sets primed=1 and moves to WAIT.
  - WAIT: src_ready=0. pend_lo -> FILL_LO with addr=0. Otherwise pend_hi -> FILL_HI with addr=half.
  - FILL_LO: handshakes write addr 0..half-1. The last handshake clears pend_lo; next state is WAIT.
  - FILL_HI: handshakes write addr half..2**ADDR_WIDTH-1. The last handshake clears pend_hi; next state is WAIT.
- Write timing is registered: mem_wr_en, mem_wr_addr and mem_dat are updated on the edge that completes the handshake. Handshake to RAM write latency is 1 cycle. mem_wr_en is high exactly one cycle per handshake.
- Throughput: one sample per cycle while src_valid stays high. src_valid low stalls without writing.
- src_ready is a combinational decode of state only and never depends on src_valid.
- Event handling:
  - evt_lsbf sets pend_lo; evt_hsbf sets pend_hi. Events are ignored in IDLE and PRIME.
  - An event for a half that is already pending, or currently being filled, sets underrun. That pend bit stays set, so exactly one further refill of that half follows.
  - Simultaneous evt_lsbf and evt_hsbf set both bits; lower half is served first.
  - An event arriving on the same edge that the last handshake of that half clears its pend bit re-sets the bit (set wins) and also sets underrun.
- clr_err clears underrun. If an underrun condition occurs in the same cycle, underrun stays 1.
- ctrl_en low in any state: on the next edge go to IDLE; clear pend_lo, pend_hi and primed; src_ready=0. A handshake completing in that same cycle is still written. underrun holds its value.
- Address arithmetic is ADDR_WIDTH bits, unsigned. Wrap from max to 0 occurs only at the PRIME→WAIT boundary.

Test Plan:
1. ADDR_WIDTH=4, ctrl_en=1, src_valid=1 constant, src_dat=0x1000+n -> 16 writes at addr 0..15 on consecutive cycles, data 0x1000..0x100F; primed=1 the cycle after the last write; src_ready=0 in WAIT.
2. After priming, pulse evt_lsbf, feed 0x2000.. -> 8 writes to addr 0..7, data 0x2000..0x2007; busy low afterwards; underrun=0.
3. Pulse evt_lsbf and evt_hsbf in the same cycle -> addr 0..7 written first, then addr 8..15, with no idle cycle beyond one WAIT cycle between the halves.
4. During FILL_HI, hold src_valid=0, then pulse evt_hsbf -> underrun=1; after the current fill completes, a second fill of addr 8..15 occurs. clr_err pulse -> underrun=0.
5. src_valid toggling 1,0,1,0 during PRIME -> writes only on valid cycles; addresses contiguous with no gaps or duplicates; mem_wr_en never high on stalled cycles.
6. Drop ctrl_en mid-PRIME at addr 5, then raise it again -> IDLE for at least one cycle, primed=0; priming restarts at addr 0. Assert wb_rst low mid-FILL_LO -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/i2s_refill_ctrl.sv
// Ping-pong refill controller for the I2S transmitter sample RAM.
// Primes the whole buffer on enable, then refills a half each time the codec frees it.
module i2s_refill_ctrl #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 14
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst,
    input  logic                  ctrl_en,
    input  logic                  clr_err,
    input  logic                  evt_lsbf,
    input  logic                  evt_hsbf,
    input  logic [DATA_WIDTH-1:0] src_dat,
    input  logic                  src_valid,
    output logic                  src_ready,
    output logic [DATA_WIDTH-1:0] mem_dat,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic                  primed,
    output logic                  busy,
    output logic                  underrun
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_HALF = ADDR_WIDTH'(1) << (ADDR_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] HALF_LAST = ADDR_HALF - ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_WAIT,
        S_FILL_LO,
        S_FILL_HI
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_pend_lo;
    logic                  r_pend_hi;
    logic                  r_primed;
    logic                  r_underrun;

    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic                  w_pend_lo_nxt;
    logic                  w_pend_hi_nxt;
    logic                  w_primed_nxt;
    logic                  w_underrun_nxt;
    logic                  w_hs;
    logic                  w_evt_ok;
    logic                  w_lo_set;
    logic                  w_hi_set;
    logic                  w_lo_err;
    logic                  w_hi_err;

    assign src_ready = (r_state == S_PRIME) || (r_state == S_FILL_LO) || (r_state == S_FILL_HI);
    assign busy      = (r_state != S_IDLE) && (r_state != S_WAIT);
    assign primed    = r_primed;
    assign underrun  = r_underrun;

    assign w_hs     = src_valid && src_ready;
    assign w_evt_ok = ctrl_en && ((r_state == S_WAIT) || (r_state == S_FILL_LO) || (r_state == S_FILL_HI));
    assign w_lo_set = w_evt_ok && evt_lsbf;
    assign w_hi_set = w_evt_ok && evt_hsbf;
    // A half that is still pending or being written cannot be freed again without losing samples.
    assign w_lo_err = w_lo_set && (r_pend_lo || (r_state == S_FILL_LO));
    assign w_hi_err = w_hi_set && (r_pend_hi || (r_state == S_FILL_HI));

    // Next-state and next-register logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_pend_lo_nxt  = r_pend_lo || w_lo_set;
        w_pend_hi_nxt  = r_pend_hi || w_hi_set;
        w_primed_nxt   = r_primed;
        w_underrun_nxt = r_underrun;

        if (clr_err) begin
            w_underrun_nxt = 1'b0;
        end
        if (w_lo_err || w_hi_err) begin
            w_underrun_nxt = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (ctrl_en) begin
                    w_state_nxt    = S_PRIME;
                    w_addr_nxt     = '0;
                    w_primed_nxt   = 1'b0;
                    w_underrun_nxt = 1'b0;
                end
            end
            S_PRIME: begin
                if (w_hs) begin
                    w_addr_nxt = r_addr + ADDR_WIDTH'(1);
                    if (r_addr == ADDR_MAX) begin
                        w_primed_nxt = 1'b1;
                        w_state_nxt  = S_WAIT;
                    end
                end
            end
            // The pend bit is consumed on fill entry so that any event during the fill
            // (including one on the final handshake) leaves exactly one more refill queued.
            S_WAIT: begin
                if (r_pend_lo) begin
                    w_state_nxt   = S_FILL_LO;
                    w_addr_nxt    = '0;
                    w_pend_lo_nxt = w_lo_set;
                end else if (r_pend_hi) begin
                    w_state_nxt   = S_FILL_HI;
                    w_addr_nxt    = ADDR_HALF;
                    w_pend_hi_nxt = w_hi_set;
                end
            end
            S_FILL_LO: begin
                if (w_hs) begin
                    if (r_addr == HALF_LAST) begin
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_addr_nxt = r_addr + ADDR_WIDTH'(1);
                    end
                end
            end
            S_FILL_HI: begin
                if (w_hs) begin
                    if (r_addr == ADDR_MAX) begin
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_addr_nxt = r_addr + ADDR_WIDTH'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (!ctrl_en) begin
            w_state_nxt   = S_IDLE;
            w_pend_lo_nxt = 1'b0;
            w_pend_hi_nxt = 1'b0;
            w_primed_nxt  = 1'b0;
        end
    end

    // State, control flags and the registered RAM write port.
    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_pend_lo   <= 1'b0;
            r_pend_hi   <= 1'b0;
            r_primed    <= 1'b0;
            r_underrun  <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_dat     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_pend_lo  <= w_pend_lo_nxt;
            r_pend_hi  <= w_pend_hi_nxt;
            r_primed   <= w_primed_nxt;
            r_underrun <= w_underrun_nxt;
            mem_wr_en  <= w_hs;
            if (w_hs) begin
                mem_wr_addr <= r_addr;
                mem_dat     <= src_dat;
            end
        end
    end

endmodule

// File: tb/tb_i2s_refill_ctrl.sv
// Bench for i2s_refill_ctrl: directed stimulus pushes expected RAM writes into a queue,
// a negedge monitor pops and compares every mem_wr_en beat.
module tb_i2s_refill_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;

    logic          wb_clk    = 1'b0;
    logic          wb_rst    = 1'b0;
    logic          ctrl_en   = 1'b0;
    logic          clr_err   = 1'b0;
    logic          evt_lsbf  = 1'b0;
    logic          evt_hsbf  = 1'b0;
    logic [DW-1:0] src_dat   = '0;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [DW-1:0] mem_dat;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic          primed;
    logic          busy;
    logic          underrun;

    int checks   = 0;
    int failures = 0;
    int stalls   = 0;
    logic [AW+DW-1:0] exp_q[$];

    i2s_refill_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .wb_clk     (wb_clk),
        .wb_rst     (wb_rst),
        .ctrl_en    (ctrl_en),
        .clr_err    (clr_err),
        .evt_lsbf   (evt_lsbf),
        .evt_hsbf   (evt_hsbf),
        .src_dat    (src_dat),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .mem_dat    (mem_dat),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_addr(mem_wr_addr),
        .primed     (primed),
        .busy       (busy),
        .underrun   (underrun)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge wb_clk);
    endtask

    // Offer one sample; the expected write is queued once the handshake is certain.
    task automatic send(input logic [DW-1:0] d, input logic [AW-1:0] a);
        int n;
        n         = 0;
        src_dat   = d;
        src_valid = 1'b1;
        while (!src_ready && n < 50) begin
            @(negedge wb_clk);
            n++;
            stalls++;
        end
        if (!src_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: src_ready=0 after 50 cycles, need 1 (addr 0x%0h)", a);
        end else begin
            exp_q.push_back({a, d});
        end
        @(negedge wb_clk);
    endtask

    // Write monitor.
    always @(negedge wb_clk) begin
        logic [AW+DW-1:0] e;
        if (wb_rst && mem_wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: addr=0x%0h data=0x%0h, no write expected",
                         mem_wr_addr, mem_dat);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr_data", 32'({mem_wr_addr, mem_dat}), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        chk("rst_src_ready", 32'(src_ready), 0);
        chk("rst_wr_en", 32'(mem_wr_en), 0);
        chk("rst_primed", 32'(primed), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_underrun", 32'(underrun), 0);
        wb_rst = 1'b1;
        tick(1);

        // Prime with a continuous source
        ctrl_en = 1'b1;
        tick(1);
        chk("prime_ready", 32'(src_ready), 1);
        chk("prime_busy", 32'(busy), 1);
        for (int i = 0; i < 16; i++) begin
            send(16'(32'h1000 + i), 4'(i));
            if (i == 14) chk("primed_early", 32'(primed), 0);
        end
        src_valid = 1'b0;
        chk("primed_set", 32'(primed), 1);
        chk("wait_ready", 32'(src_ready), 0);
        chk("wait_busy", 32'(busy), 0);

        // Lower-half refill
        evt_lsbf = 1'b1;
        tick(1);
        evt_lsbf = 1'b0;
        for (int i = 0; i < 8; i++) send(16'(32'h2000 + i), 4'(i));
        src_valid = 1'b0;
        chk("lo_busy_after", 32'(busy), 0);
        chk("lo_underrun", 32'(underrun), 0);

        // Both halves at once: lower first, one WAIT cycle between halves
        evt_lsbf = 1'b1;
        evt_hsbf = 1'b1;
        tick(1);
        evt_lsbf = 1'b0;
        evt_hsbf = 1'b0;
        send(16'h3000, 4'd0);
        stalls = 0;
        for (int i = 1; i < 16; i++) send(16'(32'h3000 + i), 4'(i));
        src_valid = 1'b0;
        chk("dual_gap_cycles", 32'(stalls), 1);
        chk("dual_busy_after", 32'(busy), 0);

        // Upper-half underrun during a stalled fill
        evt_hsbf = 1'b1;
        tick(1);
        evt_hsbf = 1'b0;
        for (int i = 0; i < 3; i++) send(16'(32'h4000 + i), 4'(8 + i));
        src_valid = 1'b0;
        tick(2);
        chk("hi_no_underrun_yet", 32'(underrun), 0);
        evt_hsbf = 1'b1;
        tick(1);
        evt_hsbf = 1'b0;
        chk("hi_underrun_set", 32'(underrun), 1);
        clr_err  = 1'b1;
        evt_hsbf = 1'b1;
        tick(1);
        clr_err  = 1'b0;
        evt_hsbf = 1'b0;
        chk("clr_vs_new_err", 32'(underrun), 1);
        for (int i = 3; i < 8; i++) send(16'(32'h4000 + i), 4'(8 + i));
        for (int i = 0; i < 8; i++) send(16'(32'h5000 + i), 4'(8 + i));
        src_valid = 1'b0;
        tick(2);
        chk("hi_single_refill", 32'(busy), 0);
        chk("hi_underrun_held", 32'(underrun), 1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("clr_err", 32'(underrun), 0);

        // Underrun survives disable, cleared on re-prime; stalled priming
        evt_lsbf = 1'b1;
        tick(2);
        evt_lsbf = 1'b0;
        chk("lo_double_evt", 32'(underrun), 1);
        ctrl_en = 1'b0;
        tick(1);
        chk("dis_ready", 32'(src_ready), 0);
        chk("dis_busy", 32'(busy), 0);
        chk("dis_primed", 32'(primed), 0);
        chk("dis_underrun_hold", 32'(underrun), 1);
        ctrl_en = 1'b1;
        tick(1);
        chk("reprime_underrun_clr", 32'(underrun), 0);
        chk("reprime_ready", 32'(src_ready), 1);
        for (int i = 0; i < 16; i++) begin
            send(16'(32'h6000 + i), 4'(i));
            src_valid = 1'b0;
            tick(1);
        end
        chk("gap_primed", 32'(primed), 1);

        // Abort priming at addr 5; the in-flight handshake still lands
        ctrl_en = 1'b0;
        tick(1);
        ctrl_en = 1'b1;
        tick(1);
        chk("restart_primed", 32'(primed), 0);
        for (int i = 0; i < 5; i++) send(16'(32'h7000 + i), 4'(i));
        ctrl_en = 1'b0;
        send(16'h7005, 4'd5);
        src_valid = 1'b0;
        chk("abort_primed", 32'(primed), 0);
        chk("abort_ready", 32'(src_ready), 0);
        chk("abort_busy", 32'(busy), 0);
        ctrl_en = 1'b1;
        tick(1);
        for (int i = 0; i < 16; i++) send(16'(32'h8000 + i), 4'(i));
        src_valid = 1'b0;
        chk("restart_primed_set", 32'(primed), 1);

        // Asynchronous reset in the middle of a lower-half fill
        evt_lsbf = 1'b1;
        tick(1);
        evt_lsbf = 1'b0;
        for (int i = 0; i < 3; i++) send(16'(32'h9000 + i), 4'(i));
        src_valid = 1'b0;
        tick(1);
        chk("fill_busy", 32'(busy), 1);
        @(posedge wb_clk);
        #2;
        wb_rst = 1'b0;
        #1;
        chk("arst_wr_en", 32'(mem_wr_en), 0);
        chk("arst_wr_addr", 32'(mem_wr_addr), 0);
        chk("arst_dat", 32'(mem_dat), 0);
        chk("arst_primed", 32'(primed), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ready", 32'(src_ready), 0);
        chk("arst_underrun", 32'(underrun), 0);
        tick(2);
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
